// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: rotates the column drive, debounces press and release of a
// single tracked key, and emits one key_valid pulse per physical keypress.
module keypad_scan_ctrl #(
    parameter int SCAN_CYCLES     = 4800,
    parameter int DEBOUNCE_CYCLES = 480000
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic [2:0] fsm_state
);

    localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        SCAN     = 3'd0,
        DB_PRESS = 3'd1,
        EMIT     = 3'd2,
        HELD     = 3'd3,
        DB_REL   = 3'd4
    } state_t;

    state_t        state;
    logic [3:0]    rs_meta;
    logic [3:0]    rs;
    logic [SW-1:0] dwell;
    logic [DW-1:0] db_cnt;
    logic [1:0]    lrow;
    logic [1:0]    lcol;
    logic [1:0]    low_row;
    logic [1:0]    col_idx;
    logic          row_bit;
    logic [3:0]    key_code;
    logic [3:0]    col_next;

    assign fsm_state = state;
    assign row_bit   = rs[lrow];
    assign col_next  = {col[2:0], col[3]};

    // Rows are asynchronous to int_osc; nothing downstream looks at the raw inputs.
    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            rs_meta <= 4'b0000;
            rs      <= 4'b0000;
        end else begin
            rs_meta <= row;
            rs      <= rs_meta;
        end
    end

    always_comb begin
        low_row = 2'd0;
        if (rs[0])      low_row = 2'd0;
        else if (rs[1]) low_row = 2'd1;
        else if (rs[2]) low_row = 2'd2;
        else if (rs[3]) low_row = 2'd3;
    end

    always_comb begin
        col_idx = 2'd0;
        case (col)
            4'b0010: col_idx = 2'd1;
            4'b0100: col_idx = 2'd2;
            4'b1000: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    always_comb begin
        key_code = 4'h0;
        case ({lrow, lcol})
            4'b00_00: key_code = 4'h1;
            4'b00_01: key_code = 4'h2;
            4'b00_10: key_code = 4'h3;
            4'b00_11: key_code = 4'hA;
            4'b01_00: key_code = 4'h4;
            4'b01_01: key_code = 4'h5;
            4'b01_10: key_code = 4'h6;
            4'b01_11: key_code = 4'hB;
            4'b10_00: key_code = 4'h7;
            4'b10_01: key_code = 4'h8;
            4'b10_10: key_code = 4'h9;
            4'b10_11: key_code = 4'hC;
            4'b11_00: key_code = 4'hE;
            4'b11_01: key_code = 4'h0;
            4'b11_10: key_code = 4'hF;
            default:  key_code = 4'hD;
        endcase
    end

    // Counters only advance below their terminal value, so they can never wrap.
    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            col       <= 4'b0001;
            key       <= 4'h0;
            key_valid <= 1'b0;
            dwell     <= '0;
            db_cnt    <= '0;
            lrow      <= 2'd0;
            lcol      <= 2'd0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (dwell == SCAN_LAST) begin
                        dwell <= '0;
                        if (rs != 4'b0000) begin
                            lrow   <= low_row;
                            lcol   <= col_idx;
                            db_cnt <= '0;
                            state  <= DB_PRESS;
                        end else begin
                            col <= col_next;
                        end
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                DB_PRESS: begin
                    if (!row_bit) begin
                        db_cnt <= '0;
                        dwell  <= '0;
                        col    <= col_next;
                        state  <= SCAN;
                    end else if (db_cnt == DB_LAST) begin
                        key       <= key_code;
                        key_valid <= 1'b1;
                        state     <= EMIT;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                EMIT: state <= HELD;
                HELD: begin
                    if (!row_bit) begin
                        db_cnt <= '0;
                        state  <= DB_REL;
                    end
                end
                DB_REL: begin
                    if (row_bit) begin
                        state <= HELD;
                    end else if (db_cnt == DB_LAST) begin
                        db_cnt <= '0;
                        dwell  <= '0;
                        col    <= col_next;
                        state  <= SCAN;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: keypad model drives rows from col, a run-length reference
// model predicts col/key/key_valid every cycle, and directed scenarios pin key events.
module tb_keypad_scan_ctrl;

    localparam int SC = 4;
    localparam int DB = 16;
    localparam int M_SCAN  = 0;
    localparam int M_PRESS = 1;
    localparam int M_EMIT  = 2;
    localparam int M_HELD  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key;
    logic       key_valid;
    logic [2:0] fsm_state;
    logic [3:0] pressed [4];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic prev_kv = 1'b0;
    logic [3:0] key_log[$];
    int pulse_log[$];

    // reference model state
    int m_mode, m_dwell, m_ci, m_r, m_c, m_run, m_low, m_cap;
    logic [3:0] m_s1, m_s2, m_key;
    logic m_kv;

    keypad_scan_ctrl #(.SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(DB)) dut (
        .int_osc(clk),
        .reset(rst),
        .row(row),
        .col(col),
        .key(key),
        .key_valid(key_valid),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    assign row[0] = |(pressed[0] & col);
    assign row[1] = |(pressed[1] & col);
    assign row[2] = |(pressed[2] & col);
    assign row[3] = |(pressed[3] & col);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int lim);
        n_checks++;
        if (act < lim) begin
            n_errors++;
            $display("FAIL %s: got %0d expected >= %0d", name, act, lim);
        end
    endtask

    function automatic logic [3:0] code_of(input int r, input int c);
        logic [63:0] tbl;
        tbl = 64'hDF0E_C987_B654_A321;
        return tbl[(r*4 + c)*4 +: 4];
    endfunction

    function automatic int key_at(input int i);
        if (i < key_log.size()) return int'(key_log[i]);
        return -1;
    endfunction

    function automatic int cyc_at(input int i);
        if (i < pulse_log.size()) return pulse_log[i];
        return -1000;
    endfunction

    task automatic model_reset();
        m_mode = M_SCAN; m_dwell = 0; m_ci = 0; m_r = 0; m_c = 0;
        m_run = 0; m_low = 0; m_key = 4'h0; m_kv = 1'b0;
        m_s1 = 4'h0; m_s2 = 4'h0;
    endtask

    // Acceptance = DB consecutive synchronised highs after capture; release = DB+1
    // consecutive lows once the pulse cycle is over.
    task automatic model_step();
        logic [3:0] rowv;
        logic [3:0] colv;
        logic b;
        if (rst) begin
            model_reset();
            return;
        end
        colv = 4'b0001 << m_ci;
        for (int r = 0; r < 4; r++) rowv[r] = |(pressed[r] & colv);
        b = m_s2[m_r];
        m_kv = 1'b0;
        case (m_mode)
            M_SCAN: begin
                if (m_dwell == SC-1) begin
                    m_dwell = 0;
                    if (m_s2 != 4'h0) begin
                        m_c = m_ci;
                        for (int r = 3; r >= 0; r--) if (m_s2[r]) m_r = r;
                        m_run = 0;
                        m_cap = cyc - 1;
                        m_mode = M_PRESS;
                    end else begin
                        m_ci = (m_ci + 1) % 4;
                    end
                end else begin
                    m_dwell++;
                end
            end
            M_PRESS: begin
                if (b) begin
                    m_run++;
                    if (m_run == DB) begin
                        m_key = code_of(m_r, m_c);
                        m_kv = 1'b1;
                        m_mode = M_EMIT;
                    end
                end else begin
                    m_ci = (m_ci + 1) % 4;
                    m_dwell = 0;
                    m_mode = M_SCAN;
                end
            end
            M_EMIT: begin
                m_low = 0;
                m_mode = M_HELD;
            end
            default: begin
                if (!b) begin
                    m_low++;
                    if (m_low == DB+1) begin
                        m_ci = (m_ci + 1) % 4;
                        m_dwell = 0;
                        m_mode = M_SCAN;
                    end
                end else begin
                    m_low = 0;
                end
            end
        endcase
        m_s2 = m_s1;
        m_s1 = rowv;
    endtask

    task automatic compare();
        logic [3:0] exp_col;
        exp_col = 4'b0001 << m_ci;
        check("col", col, exp_col);
        check("key", key, m_key);
        check("key_valid", key_valid, m_kv);
        if (key_valid) begin
            check("kv_back_to_back", prev_kv, 1'b0);
            key_log.push_back(key);
            pulse_log.push_back(cyc);
        end
        prev_kv = key_valid;
        cyc++;
    endtask

    // One clock: compare on the falling edge, advance the model on the rising edge,
    // then leave inputs changeable 1 time unit after the edge.
    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    initial begin
        int base;
        int rel;
        int stable;
        bit found;

        rst = 1'b1;
        for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
        model_reset();

        // 1: reset and column rotation
        ticks(3);
        check("rst_col", col, 4'b0001);
        check("rst_key", key, 4'h0);
        check("rst_kv", key_valid, 1'b0);
        check("rst_state", fsm_state, 3'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("rotate_col", col, (i < 4) ? 4'b0001 : 4'b0010);
            tick();
        end

        // 2: press '6', hold, release
        base = key_log.size();
        pressed[1][2] = 1'b1;
        ticks(200);
        check("s2_count_held", key_log.size() - base, 1);
        check("s2_latency", cyc_at(base) - m_cap, DB + 1);
        pressed[1][2] = 1'b0;
        ticks(60);
        check("s2_count", key_log.size() - base, 1);
        check("s2_key", key_at(base), 4'h6);

        // 3: bouncing '1', then stable
        base = key_log.size();
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) pressed[0][0] = ~pressed[0][0];
            tick();
        end
        check("s3_no_pulse_bounce", key_log.size() - base, 0);
        pressed[0][0] = 1'b1;
        stable = cyc;
        ticks(80);
        check("s3_count", key_log.size() - base, 1);
        check("s3_key", key_at(base), 4'h1);
        check_ge("s3_after_stable", cyc_at(base) - stable, DB + 1);
        pressed[0][0] = 1'b0;
        ticks(60);

        // 4: hold '1', press '9', release '1'
        base = key_log.size();
        pressed[0][0] = 1'b1;
        ticks(60);
        pressed[2][2] = 1'b1;
        ticks(100);
        check("s4_count_mid", key_log.size() - base, 1);
        pressed[0][0] = 1'b0;
        rel = cyc;
        ticks(120);
        check("s4_count", key_log.size() - base, 2);
        check("s4_key1", key_at(base), 4'h1);
        check("s4_key2", key_at(base + 1), 4'h9);
        check_ge("s4_second_delay", cyc_at(base + 1) - rel, 2*DB + 2);
        pressed[2][2] = 1'b0;
        ticks(60);

        // 5: hold 'D' with a short low glitch
        base = key_log.size();
        pressed[3][3] = 1'b1;
        ticks(60);
        pressed[3][3] = 1'b0;
        ticks(5);
        pressed[3][3] = 1'b1;
        ticks(60);
        check("s5_count", key_log.size() - base, 1);
        check("s5_key_log", key_at(base), 4'hD);
        check("s5_key_out", key, 4'hD);
        pressed[3][3] = 1'b0;
        ticks(60);

        // 6: reset during press debounce at count 8, then rescan
        base = key_log.size();
        pressed[0][3] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (m_mode == M_PRESS && m_run == 8) found = 1'b1;
        end
        check("s6_reach_count8", found, 1'b1);
        rst = 1'b1;
        model_reset();
        ticks(3);
        check("s6_rst_col", col, 4'b0001);
        check("s6_rst_key", key, 4'h0);
        check("s6_rst_state", fsm_state, 3'd0);
        check("s6_no_pulse", key_log.size() - base, 0);
        rst = 1'b0;
        ticks(60);
        check("s6_count", key_log.size() - base, 1);
        check("s6_key", key_at(base), 4'hA);
        pressed[0][3] = 1'b0;
        ticks(60);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
